// File: rtl/pacote_paridade.sv
// pacote_paridade: shared FSM state type and default word width for the serial even-parity transmitter
package pacote_paridade;
    typedef enum logic [1:0] {IDLE, DADOS, PARIDADE} estado_t;
    localparam int WIDTH_PADRAO = 8;
endpackage

// File: rtl/registrador_deslocamento.sv
// registrador_deslocamento: WIDTH-bit right shift register with load/shift enables, exposing its LSB
module registrador_deslocamento #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             lsb
);
    logic [WIDTH-1:0] q;
    // load has priority over shift; zeros fill from the top
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (load) q <= data_in;
        else if (shift) q <= q >> 1;
    end
    assign lsb = q[0];
endmodule

// File: rtl/gerador_paridade_serial.sv
// gerador_paridade_serial: serial even-parity transmitter, LSB first; PARIDADE_ERRO_EN adds force_err to invert a frame's parity
module gerador_paridade_serial
    import pacote_paridade::*;
#(
    parameter int WIDTH = WIDTH_PADRAO
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
`ifdef PARIDADE_ERRO_EN
    input  logic             force_err,
`endif
    output logic             ready,
    output logic             out_bit,
    output logic             bit_valid,
    output logic             last
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    estado_t       state;
    logic [CW-1:0] cnt;
    logic          acc;
    logic          aceita;
    logic          inv;
    logic          prox;
`ifdef PARIDADE_ERRO_EN
    assign inv = force_err;
`else
    assign inv = 1'b0;
`endif
    assign ready  = (state == IDLE) || (state == PARIDADE);
    assign aceita = start && ready;
    // bit 0 goes straight to the line on accept, so the register holds the remaining bits already aligned
    registrador_deslocamento #(.WIDTH(WIDTH)) u_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (aceita),
        .shift  (state == DADOS),
        .data_in(data_in >> 1),
        .lsb    (prox)
    );
    // frame sequencer: data bits, then the accumulated parity for one cycle; force_err is folded into acc at accept
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_bit   <= 1'b0;
            bit_valid <= 1'b0;
            last      <= 1'b0;
            acc       <= 1'b0;
            cnt       <= '0;
        end else if (aceita) begin
            state     <= DADOS;
            out_bit   <= data_in[0];
            bit_valid <= 1'b1;
            last      <= 1'b0;
            acc       <= data_in[0] ^ inv;
            cnt       <= '0;
        end else if (state == DADOS) begin
            if (cnt == CW'(WIDTH - 1)) begin
                state   <= PARIDADE;
                out_bit <= acc;
                last    <= 1'b1;
            end else begin
                out_bit <= prox;
                acc     <= acc ^ prox;
                cnt     <= cnt + 1'b1;
            end
        end else begin
            state     <= IDLE;
            out_bit   <= 1'b0;
            bit_valid <= 1'b0;
            last      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gerador_paridade_serial.sv
// tb_gerador_paridade_serial: directed bench with a frame-queue reference model checked every cycle
module tb_gerador_paridade_serial;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         force_err = 1'b0;
    logic         ready, out_bit, bit_valid, last;
    int           errors = 0;
    int           checks = 0;
    bit           chk_en = 1'b0;

    gerador_paridade_serial #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
`ifdef PARIDADE_ERRO_EN
        .force_err(force_err),
`endif
        .ready    (ready),
        .out_bit  (out_bit),
        .bit_valid(bit_valid),
        .last     (last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // reference: an accepted word becomes a list of line cycles; ready means nothing is left to send
    typedef struct packed {logic v; logic b; logic l;} ent_t;
    ent_t q[$];
    logic m_v = 0, m_b = 0, m_l = 0;
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            {m_v, m_b, m_l} = 3'b000;
        end else begin
            if (start && q.size() == 0) begin
                logic fe;
`ifdef PARIDADE_ERRO_EN
                fe = force_err;
`else
                fe = 1'b0;
`endif
                for (int i = 0; i < W; i++) q.push_back('{1'b1, data_in[i], 1'b0});
                q.push_back('{1'b1, (^data_in) ^ fe, 1'b1});
            end
            if (q.size() > 0) begin
                ent_t e;
                e = q.pop_front();
                {m_v, m_b, m_l} = {e.v, e.b, e.l};
            end else {m_v, m_b, m_l} = 3'b000;
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("m_bit_valid", bit_valid, m_v);
        chk("m_out_bit", out_bit, m_b);
        chk("m_last", last, m_l);
        chk("m_ready", ready, q.size() == 0);
    end

    logic got [0:17];
    logic lst [0:17];
    logic rdy [0:17];

    task automatic send(input logic [W-1:0] d, input logic fe);
        start = 1'b1;
        data_in = d;
        force_err = fe;
        @(negedge clk);
        start = 1'b0;
        force_err = 1'b0;
    endtask

    task automatic collect9();
        for (int i = 0; i < 9; i++) begin
            got[i] = out_bit;
            lst[i] = last;
            rdy[i] = ready;
            @(negedge clk);
        end
    endtask

    task automatic chk_frame(input string name, input logic [W-1:0] d, input logic par);
        for (int i = 0; i < W; i++) chk({name, "_bit"}, got[i], d[i]);
        chk({name, "_par"}, got[W], par);
        for (int i = 0; i <= W; i++) chk({name, "_last"}, lst[i], i == W);
    endtask

    initial begin
        int vcnt;
        int ones;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("idle_out", out_bit, 1'b0);
            chk("idle_valid", bit_valid, 1'b0);
            chk("idle_last", last, 1'b0);
            chk("idle_ready", ready, 1'b1);
            @(negedge clk);
        end
        send(8'hA5, 1'b0);
        collect9();
        chk_frame("a5", 8'b1010_0101, 1'b0);
        for (int i = 0; i < 8; i++) chk("a5_busy", rdy[i], 1'b0);
        chk("a5_ready_par", rdy[8], 1'b1);
        chk("a5_ready_idle", ready, 1'b1);
        chk("a5_idle_valid", bit_valid, 1'b0);
        start = 1'b1;
        data_in = 8'h07;
        @(negedge clk);
        vcnt = 0;
        for (int i = 0; i < 18; i++) begin
            got[i] = out_bit;
            vcnt += int'(bit_valid);
            if (i == 8) begin
                chk("b2b_ready_par", ready, 1'b1);
                start = 1'b1;
                data_in = 8'h00;
            end else start = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) chk("b2b_07_bit", got[i], i < 3);
        chk("b2b_07_par", got[8], 1'b1);
        for (int i = 9; i < 18; i++) chk("b2b_00_bit", got[i], 1'b0);
        chk("b2b_valid_run", vcnt == 18, 1'b1);
        chk("b2b_end_valid", bit_valid, 1'b0);
        send(8'h3C, 1'b0);
        for (int i = 0; i < 9; i++) begin
            got[i] = out_bit;
            lst[i] = last;
            start = (i >= 2 && i <= 5);
            data_in = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        chk_frame("inflight", 8'h3C, 1'b0);
        chk("inflight_no_extra", bit_valid, 1'b0);
        send(8'hFF, 1'b0);
        repeat (4) @(negedge clk);
        chk("rst_bit4", out_bit, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_out", out_bit, 1'b0);
        chk("rst_valid", bit_valid, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_last", last, 1'b0);
        @(negedge clk);
        send(8'h01, 1'b0);
        collect9();
        chk_frame("post_rst", 8'h01, 1'b1);
`ifdef PARIDADE_ERRO_EN
        send(8'hA5, 1'b1);
        collect9();
        chk_frame("force", 8'hA5, 1'b1);
        ones = 0;
        for (int i = 0; i <= W; i++) ones += int'(got[i]);
        chk("force_odd_flag", ones[0], 1'b1);
        send(8'hA5, 1'b0);
        collect9();
        chk_frame("force_off", 8'hA5, 1'b0);
`else
        ones = 0;
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
